// File: rtl/stage7_control_fsm.sv
// Stage-7 stack-machine control FSM: sequences fetch/decode/execute and
// drives the datapath strobes and selects from the current state.
module stage7_control_fsm #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] Opcode,
  input  logic       isZero,
  output logic       MSPWrite,
  output logic       MSPop,
  output logic       RSPWrite,
  output logic       RSPop,
  output logic       PCWrite,
  output logic       PCSource,
  output logic       PCAdd,
  output logic       ValAWrite,
  output logic       ValBWrite,
  output logic       IRWrite,
  output logic       MemRead1,
  output logic       MemRead2,
  output logic       MemWrite1,
  output logic       MemWrite2,
  output logic       ResSource,
  output logic       ResWrite,
  output logic [1:0] MemDst1,
  output logic [1:0] MemDst2,
  output logic [2:0] MemData,
  output logic [3:0] ALUop,
  output logic [2:0] State,
  output logic       Halted,
  output logic       Illegal
);

  localparam int unsigned WAIT_W    = 4;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_PUSH   = 3'd3,
    S_BRANCH = 3'd4,
    S_CALL   = 3'd5,
    S_RET    = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  state_t            state, state_nx;
  logic [WAIT_W-1:0] wait_cnt, wait_cnt_nx;
  logic [3:0]        alu_op, alu_op_nx;
  logic              from_exec, from_exec_nx;
  logic              illegal_q, illegal_nx;
  logic              fetch_last;

  assign fetch_last = (wait_cnt == WAIT_LAST);

  // State, wait counter, latched ALU function, PUSH source and sticky illegal flag
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state     <= S_FETCH;
      wait_cnt  <= '0;
      alu_op    <= '0;
      from_exec <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state     <= state_nx;
      wait_cnt  <= wait_cnt_nx;
      alu_op    <= alu_op_nx;
      from_exec <= from_exec_nx;
      illegal_q <= illegal_nx;
    end
  end

  // Next-state logic; Opcode is only consulted in DECODE and latched there
  always_comb begin
    state_nx     = state;
    wait_cnt_nx  = wait_cnt;
    alu_op_nx    = alu_op;
    from_exec_nx = from_exec;
    illegal_nx   = illegal_q;
    case (state)
      S_FETCH: begin
        if (fetch_last) begin
          state_nx    = S_DECODE;
          wait_cnt_nx = '0;
        end else begin
          wait_cnt_nx = wait_cnt + WAIT_W'(1);
        end
      end
      S_DECODE: begin
        alu_op_nx    = Opcode - 4'd1;
        from_exec_nx = 1'b0;
        case (Opcode)
          4'h0:                   state_nx = S_FETCH;
          4'h1, 4'h2, 4'h3, 4'h4: state_nx = S_EXEC;
          4'h5:                   state_nx = S_PUSH;
          4'h6:                   state_nx = S_BRANCH;
          4'h7:                   state_nx = S_CALL;
          4'h8:                   state_nx = S_RET;
          4'h9:                   state_nx = S_HALT;
          default: begin
            state_nx   = S_HALT;
            illegal_nx = 1'b1;
          end
        endcase
      end
      S_EXEC: begin
        state_nx     = S_PUSH;
        from_exec_nx = 1'b1;
      end
      S_PUSH, S_BRANCH, S_CALL, S_RET: state_nx = S_FETCH;
      S_HALT:  state_nx = S_HALT;
      default: state_nx = S_FETCH;
    endcase
  end

  // Output decode from state; everything is held at zero while reset is low
  always_comb begin
    MSPWrite  = 1'b0;
    MSPop     = 1'b0;
    RSPWrite  = 1'b0;
    RSPop     = 1'b0;
    PCWrite   = 1'b0;
    PCSource  = 1'b0;
    PCAdd     = 1'b0;
    ValAWrite = 1'b0;
    ValBWrite = 1'b0;
    IRWrite   = 1'b0;
    MemRead1  = 1'b0;
    MemRead2  = 1'b0;
    MemWrite1 = 1'b0;
    MemWrite2 = 1'b0;
    ResSource = 1'b0;
    ResWrite  = 1'b0;
    MemDst1   = 2'b00;
    MemDst2   = 2'b00;
    MemData   = 3'b000;
    ALUop     = 4'b0000;
    State     = 3'd0;
    Halted    = 1'b0;
    Illegal   = 1'b0;
    if (RESET_N) begin
      State   = state;
      Illegal = illegal_q;
      case (state)
        S_FETCH: begin
          MemRead1 = 1'b1;
          if (fetch_last) begin
            IRWrite = 1'b1;
            PCWrite = 1'b1;
            PCAdd   = 1'b1;
          end
        end
        S_DECODE: begin
          MemRead1  = 1'b1;
          MemDst1   = 2'b01;
          ValAWrite = 1'b1;
          MemRead2  = 1'b1;
          MemDst2   = 2'b01;
          ValBWrite = 1'b1;
        end
        S_EXEC: begin
          ALUop    = alu_op;
          ResWrite = 1'b1;
          MSPWrite = 1'b1;
          MSPop    = 1'b1;
        end
        S_PUSH: begin
          MemWrite1 = 1'b1;
          MemDst1   = 2'b01;
          MemData   = from_exec ? 3'b010 : 3'b011;
          MSPWrite  = 1'b1;
        end
        S_BRANCH: begin
          MSPWrite = 1'b1;
          MSPop    = 1'b1;
          PCWrite  = isZero;
          PCSource = 1'b1;
        end
        S_CALL: begin
          MemWrite2 = 1'b1;
          MemDst2   = 2'b10;
          MemData   = 3'b100;
          RSPWrite  = 1'b1;
          PCWrite   = 1'b1;
          PCSource  = 1'b1;
        end
        S_RET: begin
          MemRead2  = 1'b1;
          MemDst2   = 2'b10;
          RSPWrite  = 1'b1;
          RSPop     = 1'b1;
          PCWrite   = 1'b1;
          PCSource  = 1'b1;
          ResSource = 1'b1;
        end
        S_HALT:  Halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_stage7_control_fsm.sv
// Directed bench for stage7_control_fsm: MEM_WAIT=0 and MEM_WAIT=3 instances
// share stimulus; outputs are packed into one word per instance for checking.
module tb_stage7_control_fsm;

  logic       CLK = 1'b0;
  logic       RESET_N = 1'b0;
  logic [3:0] Opcode = 4'h0;
  logic       isZero = 1'b0;

  int n_chk = 0;
  int n_bad = 0;

  // Instance 0 (MEM_WAIT=0) outputs
  logic a_mspw, a_mspop, a_rspw, a_rspop, a_pcw, a_pcsrc, a_pcadd, a_vala, a_valb, a_irw;
  logic a_mr1, a_mr2, a_mw1, a_mw2, a_ressrc, a_resw, a_halted, a_illegal;
  logic [1:0] a_dst1, a_dst2;
  logic [2:0] a_mdata, a_state;
  logic [3:0] a_alu;
  // Instance 3 (MEM_WAIT=3) outputs
  logic b_mspw, b_mspop, b_rspw, b_rspop, b_pcw, b_pcsrc, b_pcadd, b_vala, b_valb, b_irw;
  logic b_mr1, b_mr2, b_mw1, b_mw2, b_ressrc, b_resw, b_halted, b_illegal;
  logic [1:0] b_dst1, b_dst2;
  logic [2:0] b_mdata, b_state;
  logic [3:0] b_alu;

  stage7_control_fsm #(.MEM_WAIT(0)) u0 (
    .CLK(CLK), .RESET_N(RESET_N), .Opcode(Opcode), .isZero(isZero),
    .MSPWrite(a_mspw), .MSPop(a_mspop), .RSPWrite(a_rspw), .RSPop(a_rspop),
    .PCWrite(a_pcw), .PCSource(a_pcsrc), .PCAdd(a_pcadd), .ValAWrite(a_vala),
    .ValBWrite(a_valb), .IRWrite(a_irw), .MemRead1(a_mr1), .MemRead2(a_mr2),
    .MemWrite1(a_mw1), .MemWrite2(a_mw2), .ResSource(a_ressrc), .ResWrite(a_resw),
    .MemDst1(a_dst1), .MemDst2(a_dst2), .MemData(a_mdata), .ALUop(a_alu),
    .State(a_state), .Halted(a_halted), .Illegal(a_illegal)
  );

  stage7_control_fsm #(.MEM_WAIT(3)) u3 (
    .CLK(CLK), .RESET_N(RESET_N), .Opcode(Opcode), .isZero(isZero),
    .MSPWrite(b_mspw), .MSPop(b_mspop), .RSPWrite(b_rspw), .RSPop(b_rspop),
    .PCWrite(b_pcw), .PCSource(b_pcsrc), .PCAdd(b_pcadd), .ValAWrite(b_vala),
    .ValBWrite(b_valb), .IRWrite(b_irw), .MemRead1(b_mr1), .MemRead2(b_mr2),
    .MemWrite1(b_mw1), .MemWrite2(b_mw2), .ResSource(b_ressrc), .ResWrite(b_resw),
    .MemDst1(b_dst1), .MemDst2(b_dst2), .MemData(b_mdata), .ALUop(b_alu),
    .State(b_state), .Halted(b_halted), .Illegal(b_illegal)
  );

  // Packed view: {State, Halted, Illegal, ALUop, MemData, MemDst1, MemDst2, strobes[15:0]}
  // strobes: MSPWrite MSPop RSPWrite RSPop PCWrite PCSource PCAdd ValAWrite
  //          ValBWrite IRWrite MemRead1 MemRead2 MemWrite1 MemWrite2 ResSource ResWrite
  logic [31:0] obs0, obs3;
  assign obs0 = {a_state, a_halted, a_illegal, a_alu, a_mdata, a_dst1, a_dst2,
                 a_mspw, a_mspop, a_rspw, a_rspop, a_pcw, a_pcsrc, a_pcadd, a_vala,
                 a_valb, a_irw, a_mr1, a_mr2, a_mw1, a_mw2, a_ressrc, a_resw};
  assign obs3 = {b_state, b_halted, b_illegal, b_alu, b_mdata, b_dst1, b_dst2,
                 b_mspw, b_mspop, b_rspw, b_rspop, b_pcw, b_pcsrc, b_pcadd, b_vala,
                 b_valb, b_irw, b_mr1, b_mr2, b_mw1, b_mw2, b_ressrc, b_resw};

  always #5 CLK = ~CLK;

  function automatic logic [31:0] ev(input logic [2:0] st, input logic h, input logic il,
                                     input logic [3:0] alu, input logic [2:0] md,
                                     input logic [1:0] d1, input logic [1:0] d2,
                                     input logic [15:0] s);
    return {st, h, il, alu, md, d1, d2, s};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Drive inputs at the falling edge and let them settle before sampling
  task automatic cyc(input logic rn, input logic [3:0] op, input logic z);
    @(negedge CLK);
    RESET_N = rn;
    Opcode  = op;
    isZero  = z;
    #1;
  endtask

  logic [31:0] V_F, V_FW, V_D, V_PR, V_PI, V_B1, V_B0, V_CA, V_RT, V_H, V_HI;

  initial begin
    V_F  = ev(3'd0, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'h0A60);
    V_FW = ev(3'd0, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'h0020);
    V_D  = ev(3'd1, 1'b0, 1'b0, 4'h0, 3'b000, 2'b01, 2'b01, 16'h01B0);
    V_PR = ev(3'd3, 1'b0, 1'b0, 4'h0, 3'b010, 2'b01, 2'b00, 16'h8008);
    V_PI = ev(3'd3, 1'b0, 1'b0, 4'h0, 3'b011, 2'b01, 2'b00, 16'h8008);
    V_B1 = ev(3'd4, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'hCC00);
    V_B0 = ev(3'd4, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'hC400);
    V_CA = ev(3'd5, 1'b0, 1'b0, 4'h0, 3'b100, 2'b00, 2'b10, 16'h2C04);
    V_RT = ev(3'd6, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b10, 16'h3C12);
    V_H  = ev(3'd7, 1'b1, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'h0000);
    V_HI = ev(3'd7, 1'b1, 1'b1, 4'h0, 3'b000, 2'b00, 2'b00, 16'h0000);

    // Reset holds everything at zero
    cyc(1'b0, 4'h3, 1'b1); chk("rst0", obs0, 32'h0);
    cyc(1'b0, 4'h7, 1'b0); chk("rst3", obs3, 32'h0);

    // ADD: 0,1,2,3,0
    cyc(1'b1, 4'h0, 1'b0); chk("add_f", obs0, V_F);
    cyc(1'b1, 4'h1, 1'b0); chk("add_d", obs0, V_D);
    cyc(1'b1, 4'hF, 1'b1); chk("add_e", obs0, ev(3'd2, 1'b0, 1'b0, 4'h0, 3'b000, 2'b00, 2'b00, 16'hC001));
    cyc(1'b1, 4'h9, 1'b1); chk("add_p", obs0, V_PR);
    // SUB
    cyc(1'b1, 4'h0, 1'b0); chk("sub_f", obs0, V_F);
    cyc(1'b1, 4'h2, 1'b0); chk("sub_d", obs0, V_D);
    cyc(1'b1, 4'h0, 1'b0); chk("sub_e", obs0, ev(3'd2, 1'b0, 1'b0, 4'h1, 3'b000, 2'b00, 2'b00, 16'hC001));
    cyc(1'b1, 4'h0, 1'b0); chk("sub_p", obs0, V_PR);
    // PUSHI
    cyc(1'b1, 4'h0, 1'b0); chk("pi_f", obs0, V_F);
    cyc(1'b1, 4'h5, 1'b0); chk("pi_d", obs0, V_D);
    cyc(1'b1, 4'h1, 1'b0); chk("pi_p", obs0, V_PI);
    // JZ taken, then not taken (Opcode garbage in BRANCH ignored)
    cyc(1'b1, 4'h0, 1'b0); chk("jz1_f", obs0, V_F);
    cyc(1'b1, 4'h6, 1'b0); chk("jz1_d", obs0, V_D);
    cyc(1'b1, 4'h9, 1'b1); chk("jz1_b", obs0, V_B1);
    cyc(1'b1, 4'h0, 1'b1); chk("jz0_f", obs0, V_F);
    cyc(1'b1, 4'h6, 1'b1); chk("jz0_d", obs0, V_D);
    cyc(1'b1, 4'h9, 1'b0); chk("jz0_b", obs0, V_B0);
    // CALL, RET, NOP
    cyc(1'b1, 4'h0, 1'b0); chk("call_f", obs0, V_F);
    cyc(1'b1, 4'h7, 1'b0); chk("call_d", obs0, V_D);
    cyc(1'b1, 4'h0, 1'b0); chk("call_x", obs0, V_CA);
    cyc(1'b1, 4'h0, 1'b0); chk("ret_f", obs0, V_F);
    cyc(1'b1, 4'h8, 1'b0); chk("ret_d", obs0, V_D);
    cyc(1'b1, 4'h0, 1'b0); chk("ret_x", obs0, V_RT);
    cyc(1'b1, 4'h0, 1'b0); chk("nop_f", obs0, V_F);
    cyc(1'b1, 4'h0, 1'b0); chk("nop_d", obs0, V_D);
    cyc(1'b1, 4'h9, 1'b0); chk("nop_f2", obs0, V_F);
    // Legal HALT holds until reset
    cyc(1'b1, 4'h9, 1'b0); chk("hlt_d", obs0, V_D);
    cyc(1'b1, 4'h0, 1'b1); chk("hlt_h0", obs0, V_H);
    cyc(1'b1, 4'h1, 1'b0); chk("hlt_h1", obs0, V_H);

    // MEM_WAIT=3 instance: 4 FETCH cycles, DECODE, FETCH
    cyc(1'b0, 4'h0, 1'b0); chk("mw_rst", obs3, 32'h0);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_f0", obs3, V_FW);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_f1", obs3, V_FW);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_f2", obs3, V_FW);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_f3", obs3, V_F);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_d", obs3, V_D);
    cyc(1'b1, 4'h0, 1'b0); chk("mw_f", obs3, V_FW);

    // Illegal opcode: sticky HALT under random inputs, cleared by one reset edge
    cyc(1'b0, 4'h0, 1'b0); chk("il_rst", obs0, 32'h0);
    cyc(1'b1, 4'h0, 1'b0); chk("il_f", obs0, V_F);
    cyc(1'b1, 4'hC, 1'b0); chk("il_d", obs0, V_D);
    for (int i = 0; i < 20; i++) begin
      cyc(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      chk("il_hold", obs0, V_HI);
    end
    cyc(1'b0, 4'h5, 1'b1); chk("il_clr", obs0, 32'h0);
    cyc(1'b1, 4'h0, 1'b0); chk("il_f2", obs0, V_F);

    // Reset asserted during EXEC of OR
    cyc(1'b1, 4'h4, 1'b0); chk("re_d", obs0, V_D);
    cyc(1'b1, 4'h2, 1'b0); chk("re_e", obs0, ev(3'd2, 1'b0, 1'b0, 4'h3, 3'b000, 2'b00, 2'b00, 16'hC001));
    cyc(1'b0, 4'h2, 1'b0); chk("re_z0", obs0, 32'h0);
    cyc(1'b0, 4'h2, 1'b0); chk("re_z1", obs0, 32'h0);
    cyc(1'b1, 4'h0, 1'b0); chk("re_f", obs0, V_F);
    cyc(1'b1, 4'h0, 1'b0); chk("re_dn", obs0, V_D);
    cyc(1'b1, 4'h0, 1'b0); chk("re_fn", obs0, V_F);

    // Random instruction stream: write-strobe invariants
    begin
      int ninst = 0;
      int ncyc = 0;
      while (ninst < 1000 && ncyc < 20000) begin
        cyc(a_state == 3'd7 ? 1'b0 : 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
        ncyc++;
        if (RESET_N && a_state == 3'd0) ninst++;
        chk("rnd_wx", 32'(a_mw1 & a_mw2), 32'h0);
        chk("rnd_wfd", 32'((a_state <= 3'd1) && (a_mw1 | a_mw2)), 32'h0);
      end
      chk("rnd_budget", 32'(ninst >= 1000), 32'h1);
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/stage7_control_fsm.md
STAGE7_CONTROL_FSM -- requirements
Module: stage7_control_fsm

Interface
REQ-001 Parameter MEM_WAIT, default 0, extra wait cycles inserted in FETCH before instruction capture (0..15).
REQ-002 CLK  in  1  single system clock; all state changes on rising edge.
REQ-003 RESET_N  in  1  synchronous active-low reset; sampled on CLK rising edge.
REQ-004 Opcode  in  4  IROut[15:12] from datapath; meaningful only in DECODE.
REQ-005 isZero  in  1  datapath zero flag; meaningful only in BRANCH.
REQ-006 MSPWrite, MSPop, RSPWrite, RSPop, PCWrite, PCSource, PCAdd, ValAWrite, ValBWrite, IRWrite, MemRead1, MemRead2, MemWrite1, MemWrite2, ResSource, ResWrite  out  1 each  datapath strobes/selects.
REQ-007 MemDst1, MemDst2  out  2 each  address select: 00=PC, 01=MSP, 10=RSP, 11=unused.
REQ-008 MemData  out  3  write-data select: 000=ValA, 001=ValB, 010=Res, 011=SignExt, 100=PC.
REQ-009 ALUop  out  4  ALU function: 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
REQ-010 State  out  3  current state encoding, debug.
REQ-011 Halted  out  1  high while in HALT.
REQ-012 Illegal  out  1  sticky, set on illegal opcode, cleared only by reset.

Function
REQ-013 States (encoding): FETCH=0, DECODE=1, EXEC=2, PUSH=3, BRANCH=4, CALL=5, RET=6, HALT=7; Moore outputs except PCWrite in BRANCH.
REQ-014 Every output not listed for a state SHALL be 0.
REQ-015 FETCH: MemRead1=1, MemDst1=00 every FETCH cycle; wait counter counts 0..MEM_WAIT; on final cycle only IRWrite=1, PCWrite=1, PCAdd=1, PCSource=0, then -> DECODE.
REQ-016 MEM_WAIT=0: FETCH lasts exactly 1 cycle; MEM_WAIT=N: N+1 cycles; counter clears on FETCH exit.
REQ-017 DECODE (1 cycle): MemRead1=1, MemDst1=01, ValAWrite=1, MemRead2=1, MemDst2=01, ValBWrite=1; next by Opcode: 0x0 NOP -> FETCH; 0x1-0x4 -> EXEC; 0x5 PUSHI -> PUSH; 0x6 JZ -> BRANCH; 0x7 CALL -> CALL; 0x8 RET -> RET; 0x9 HALT -> HALT; 0xA-0xF -> HALT with Illegal set.
REQ-018 EXEC (1 cycle): ALUop=Opcode-1, ResSource=0, ResWrite=1, MSPWrite=1, MSPop=1 -> PUSH.
REQ-019 PUSH (1 cycle): MemWrite1=1, MemDst1=01, MemData=010 if arrived from EXEC, 011 if from DECODE (PUSHI); MSPWrite=1, MSPop=0 -> FETCH.
REQ-020 BRANCH (1 cycle): MSPWrite=1, MSPop=1; PCWrite=isZero, PCSource=1 -> FETCH.
REQ-021 CALL (1 cycle): MemWrite2=1, MemDst2=10, MemData=100, RSPWrite=1, RSPop=0, PCWrite=1, PCSource=1 -> FETCH.
REQ-022 RET (1 cycle): MemRead2=1, MemDst2=10, RSPWrite=1, RSPop=1, PCWrite=1, PCSource=1, ResSource=1 -> FETCH.
REQ-023 HALT: all strobes 0, Halted=1; remains until reset regardless of inputs.
REQ-024 Latencies (MEM_WAIT=0): NOP 2, ALU op 4, PUSHI 3, JZ/CALL/RET 3 cycles, FETCH to FETCH.
REQ-025 At most one of MemWrite1/MemWrite2 high in any cycle; no write strobe asserted in FETCH or DECODE.
REQ-026 Opcode and isZero changes outside DECODE/BRANCH SHALL have no effect.

Reset
REQ-027 RESET_N=0 at a rising edge: next state FETCH, wait counter 0, Illegal=0, Halted=0, all strobes 0 in the cycle following reset edge except FETCH outputs once RESET_N=1.
REQ-028 While RESET_N=0, outputs SHALL be forced to the all-zero value (State=0), including mid-instruction and in HALT.
REQ-029 Reset has priority over every transition, including HALT hold and wait counting.

Verification
REQ-030 MEM_WAIT=0, Opcode=0x1 -> State sequence 0,1,2,3,0; ALUop=0000 in EXEC; MemData=010 in PUSH.
REQ-031 Opcode=0x6, isZero=1 then repeat with isZero=0 -> PCWrite=1 then 0 in BRANCH; MSPWrite=1 both times.
REQ-032 MEM_WAIT=3, Opcode=0x0 -> FETCH 4 cycles, IRWrite/PCWrite high only in 4th, then DECODE, FETCH.
REQ-033 Opcode=0xC -> HALT, Illegal=1, Halted=1 held 20 cycles with random Opcode/isZero; RESET_N=0 one edge -> State=0, Illegal=0.
REQ-034 RESET_N=0 asserted during EXEC of Opcode=0x4 -> next cycle all outputs 0, State=0; release -> normal FETCH.
REQ-035 Random opcode stream 1000 instructions -> never MemWrite1&MemWrite2, never write strobe in FETCH/DECODE.
